// File: rtl/axi_uart_fifo_bridge.sv
// AXI4 single-beat slave bridging the PS to the Camera Link UART and CC lines.
// TX/RX bytes are buffered in FIFOs; a paced engine feeds the UART transmitter.
module axi_uart_fifo_bridge #(
   parameter int AXI_ADDR_WIDTH = 6,
   parameter int AXI_DATA_WIDTH = 128,
   parameter int AXI_ID_WIDTH   = 16,
   parameter int TX_DEPTH       = 16,
   parameter int RX_DEPTH       = 16,
   parameter int CC_WIDTH       = 4
) (
   input  logic                      s_axi_aclk,
   input  logic                      s_axi_aresetn,
   input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
   input  logic [AXI_ID_WIDTH-1:0]   s_axi_awid,
   input  logic                      s_axi_awvalid,
   output logic                      s_axi_awready,
   input  logic [AXI_DATA_WIDTH-1:0] s_axi_wdata,
   input  logic                      s_axi_wvalid,
   output logic                      s_axi_wready,
   output logic                      s_axi_bvalid,
   input  logic                      s_axi_bready,
   output logic [1:0]                s_axi_bresp,
   output logic [AXI_ID_WIDTH-1:0]   s_axi_bid,
   input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic [AXI_ID_WIDTH-1:0]   s_axi_arid,
   input  logic                      s_axi_arvalid,
   output logic                      s_axi_arready,
   output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
   output logic                      s_axi_rvalid,
   input  logic                      s_axi_rready,
   output logic [1:0]                s_axi_rresp,
   output logic                      s_axi_rlast,
   output logic [AXI_ID_WIDTH-1:0]   s_axi_rid,
   output logic                      tx_start,
   output logic [7:0]                tx_data,
   input  logic                      tx_busy,
   input  logic                      rx_ready,
   input  logic [7:0]                rx_data,
   output logic [CC_WIDTH-1:0]       cc
);

   localparam int TXA = $clog2(TX_DEPTH);
   localparam int RXA = $clog2(RX_DEPTH);
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_RESP} r_state_t;
   typedef enum logic [1:0] {T_IDLE, T_ISSUE, T_GUARD, T_WAIT} t_state_t;

   w_state_t w_state;
   r_state_t r_state;
   t_state_t t_state;

   logic [7:0]   tx_mem [TX_DEPTH];
   logic [7:0]   rx_mem [RX_DEPTH];
   logic [TXA-1:0] tx_wp, tx_rp;
   logic [RXA-1:0] rx_wp, rx_rp;
   logic [TXA:0] tx_cnt;
   logic [RXA:0] rx_cnt;
   logic tx_full, tx_empty, rx_full, rx_empty;
   logic tx_ovf, rx_ovf;
   logic [5:0] aw_addr_q;
   logic w_fire, ar_fire;
   logic wa_tx, wa_cc, wa_sts;
   logic tx_push, tx_pop, rx_push, rx_pop;
   logic [31:0] status, rd_word;
   logic rd_err;
   logic unused_bits;

   assign unused_bits = ^s_axi_wdata[AXI_DATA_WIDTH-1:8];

   assign tx_full  = tx_cnt == (TXA+1)'(TX_DEPTH);
   assign tx_empty = tx_cnt == '0;
   assign rx_full  = rx_cnt == (RXA+1)'(RX_DEPTH);
   assign rx_empty = rx_cnt == '0;

   assign w_fire  = s_axi_wready & s_axi_wvalid;
   assign ar_fire = s_axi_arready & s_axi_arvalid;
   assign wa_tx   = aw_addr_q == 6'h00;
   assign wa_cc   = aw_addr_q == 6'h04;
   assign wa_sts  = aw_addr_q == 6'h08;

   // a full FIFO still accepts a push when the head leaves in the same cycle
   assign tx_pop  = t_state == T_ISSUE;
   assign tx_push = w_fire & wa_tx & (~tx_full | tx_pop);
   assign rx_pop  = ar_fire & (s_axi_araddr[5:0] == 6'h00) & ~rx_empty;
   assign rx_push = rx_ready & (~rx_full | rx_pop);

   assign status = {8'h00, 8'(rx_cnt), 8'(tx_cnt), 2'b00,
                    rx_ovf, tx_ovf, rx_full, rx_empty, tx_full, tx_empty};

   always_comb begin
      rd_word = '0;
      rd_err  = 1'b0;
      unique case (1'b1)
         (s_axi_araddr[5:0] == 6'h00):
            rd_word = rx_empty ? '0 : {23'h0, 1'b1, rx_mem[rx_rp]};
         (s_axi_araddr[5:0] == 6'h08):
            rd_word = status;
         default:
            rd_err = 1'b1;
      endcase
   end

   always_ff @(posedge s_axi_aclk) begin
      if (tx_push) tx_mem[tx_wp] <= s_axi_wdata[7:0];
      if (rx_push) rx_mem[rx_wp] <= rx_data;
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         tx_wp  <= '0;
         tx_rp  <= '0;
         tx_cnt <= '0;
         rx_wp  <= '0;
         rx_rp  <= '0;
         rx_cnt <= '0;
         tx_ovf <= 1'b0;
         rx_ovf <= 1'b0;
         cc     <= '0;
      end else begin
         if (tx_push) tx_wp <= tx_wp + 1'b1;
         if (tx_pop)  tx_rp <= tx_rp + 1'b1;
         if (tx_push & ~tx_pop) tx_cnt <= tx_cnt + 1'b1;
         else if (~tx_push & tx_pop) tx_cnt <= tx_cnt - 1'b1;
         if (rx_push) rx_wp <= rx_wp + 1'b1;
         if (rx_pop)  rx_rp <= rx_rp + 1'b1;
         if (rx_push & ~rx_pop) rx_cnt <= rx_cnt + 1'b1;
         else if (~rx_push & rx_pop) rx_cnt <= rx_cnt - 1'b1;
         if (w_fire & wa_tx & ~tx_push) tx_ovf <= 1'b1;
         else if (w_fire & wa_sts & s_axi_wdata[0]) tx_ovf <= 1'b0;
         if (rx_ready & ~rx_push) rx_ovf <= 1'b1;
         else if (w_fire & wa_sts & s_axi_wdata[1]) rx_ovf <= 1'b0;
         if (w_fire & wa_cc) cc <= s_axi_wdata[CC_WIDTH-1:0];
      end
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         w_state       <= W_IDLE;
         s_axi_awready <= 1'b0;
         s_axi_wready  <= 1'b0;
         s_axi_bvalid  <= 1'b0;
         s_axi_bresp   <= OKAY;
         s_axi_bid     <= '0;
         aw_addr_q     <= '0;
      end else begin
         unique case (w_state)
            W_IDLE: begin
               if (s_axi_awready & s_axi_awvalid) begin
                  aw_addr_q     <= s_axi_awaddr[5:0];
                  s_axi_bid     <= s_axi_awid;
                  s_axi_awready <= 1'b0;
                  s_axi_wready  <= 1'b1;
                  w_state       <= W_DATA;
               end else begin
                  s_axi_awready <= 1'b1;
               end
            end
            W_DATA: begin
               if (w_fire) begin
                  s_axi_wready <= 1'b0;
                  s_axi_bvalid <= 1'b1;
                  s_axi_bresp  <= ((wa_tx & ~tx_push) |
                                   ~(wa_tx | wa_cc | wa_sts)) ? SLVERR : OKAY;
                  w_state      <= W_RESP;
               end
            end
            W_RESP: begin
               if (s_axi_bready) begin
                  s_axi_bvalid  <= 1'b0;
                  s_axi_awready <= 1'b1;
                  w_state       <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         r_state       <= R_IDLE;
         s_axi_arready <= 1'b0;
         s_axi_rvalid  <= 1'b0;
         s_axi_rlast   <= 1'b0;
         s_axi_rdata   <= '0;
         s_axi_rresp   <= OKAY;
         s_axi_rid     <= '0;
      end else begin
         unique case (r_state)
            R_IDLE: begin
               if (ar_fire) begin
                  s_axi_arready <= 1'b0;
                  s_axi_rvalid  <= 1'b1;
                  s_axi_rlast   <= 1'b1;
                  s_axi_rdata   <= AXI_DATA_WIDTH'(rd_word);
                  s_axi_rresp   <= rd_err ? SLVERR : OKAY;
                  s_axi_rid     <= s_axi_arid;
                  r_state       <= R_RESP;
               end else begin
                  s_axi_arready <= 1'b1;
               end
            end
            R_RESP: begin
               if (s_axi_rready) begin
                  s_axi_rvalid  <= 1'b0;
                  s_axi_rlast   <= 1'b0;
                  s_axi_arready <= 1'b1;
                  r_state       <= R_IDLE;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   // tx_busy may lag tx_start by a cycle, hence the guard state
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         t_state  <= T_IDLE;
         tx_start <= 1'b0;
         tx_data  <= '0;
      end else begin
         tx_start <= 1'b0;
         unique case (t_state)
            T_IDLE: begin
               if (!tx_empty && !tx_busy) begin
                  tx_start <= 1'b1;
                  tx_data  <= tx_mem[tx_rp];
                  t_state  <= T_ISSUE;
               end
            end
            T_ISSUE: t_state <= T_GUARD;
            T_GUARD: t_state <= T_WAIT;
            T_WAIT: if (!tx_busy) t_state <= T_IDLE;
            default: t_state <= T_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_uart_fifo_bridge.sv
// Bench for axi_uart_fifo_bridge: vector table, directed corners,
// and randomized traffic against a queue-based reference model.
module tb_axi_uart_fifo_bridge;

   localparam int DEP = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic [5:0] awaddr, araddr;
   logic [15:0] awid, arid, bid, rid;
   logic awvalid, awready, wvalid, wready, bvalid, bready;
   logic arvalid, arready, rvalid, rready, rlast;
   logic [127:0] wdata, rdata;
   logic [1:0] bresp, rresp;
   logic tx_start, rx_ready;
   logic tx_busy = 1'b0;
   logic [7:0] tx_data, rx_data;
   logic [3:0] cc;

   axi_uart_fifo_bridge dut (
      .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
      .s_axi_awaddr(awaddr), .s_axi_awid(awid),
      .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
      .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_bresp(bresp), .s_axi_bid(bid),
      .s_axi_araddr(araddr), .s_axi_arid(arid),
      .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rdata(rdata), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
      .s_axi_rresp(rresp), .s_axi_rlast(rlast), .s_axi_rid(rid),
      .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
      .rx_ready(rx_ready), .rx_data(rx_data), .cc(cc)
   );

   int compared = 0;
   int mismatched = 0;

   task automatic chk(input string name, input logic [127:0] act,
                      input logic [127:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic tmo(input string name);
      compared++;
      mismatched++;
      $display("FAIL %s: got timeout required handshake", name);
   endtask

   // reference model
   logic [7:0] tx_q[$];
   logic [7:0] rx_q[$];
   logic m_txovf, m_rxovf;
   logic [3:0] m_cc;

   function automatic void m_clear();
      tx_q.delete();
      rx_q.delete();
      m_txovf = 1'b0;
      m_rxovf = 1'b0;
      m_cc = 4'h0;
   endfunction

   function automatic logic [31:0] m_status();
      logic [7:0] rc, tc;
      rc = 8'(rx_q.size());
      tc = 8'(tx_q.size());
      return {8'h00, rc, tc, 2'b00, m_rxovf, m_txovf,
              rx_q.size() == DEP, rx_q.size() == 0,
              tx_q.size() == DEP, tx_q.size() == 0};
   endfunction

   function automatic logic [1:0] m_write(input logic [5:0] a,
                                          input logic [31:0] d);
      logic [1:0] r;
      r = 2'b00;
      case (a)
         6'h00: begin
            if (tx_q.size() < DEP) tx_q.push_back(d[7:0]);
            else begin
               m_txovf = 1'b1;
               r = 2'b10;
            end
         end
         6'h04: m_cc = d[3:0];
         6'h08: begin
            if (d[0]) m_txovf = 1'b0;
            if (d[1]) m_rxovf = 1'b0;
         end
         default: r = 2'b10;
      endcase
      return r;
   endfunction

   task automatic m_read(input logic [5:0] a, output logic [31:0] d,
                         output logic [1:0] r);
      d = 32'h0;
      r = 2'b00;
      case (a)
         6'h00: if (rx_q.size() > 0) d = {23'h0, 1'b1, rx_q.pop_front()};
         6'h08: d = m_status();
         default: r = 2'b10;
      endcase
   endtask

   function automatic void m_rx(input logic [7:0] b);
      if (rx_q.size() < DEP) rx_q.push_back(b);
      else m_rxovf = 1'b1;
   endfunction

   // UART stand-in: busy for 10 cycles after each pulse, or held high
   logic busy_hold = 1'b0;
   int busy_cnt = 0;
   int pulses = 0;
   int cyc = 0;
   int last_cyc = 0;
   bit have_last = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         busy_cnt = 0;
         have_last = 1'b0;
         tx_busy = busy_hold;
      end else begin
         cyc++;
         if (tx_start) begin
            pulses++;
            chk("start_while_busy", tx_busy, 1'b0);
            if (have_last) chk("tx_spacing", (cyc - last_cyc) >= 3, 1'b1);
            last_cyc = cyc;
            have_last = 1'b1;
            if (tx_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL tx_unexpected: got byte %0h required none", tx_data);
            end else begin
               chk("tx_data", tx_data, tx_q.pop_front());
            end
            busy_cnt = 10;
         end else if (busy_cnt > 0) begin
            busy_cnt--;
         end
         tx_busy = busy_hold || (busy_cnt > 0);
      end
   end

   task automatic axi_write(input logic [5:0] a, input logic [31:0] d,
                            input logic [15:0] id, input int hold,
                            output logic [1:0] resp);
      int n;
      logic [1:0] er, r0;
      resp = 2'b11;
      awaddr = a;
      awid = id;
      awvalid = 1'b1;
      n = 0;
      while (!awready && n < 100) begin @(posedge clk); #1; n++; end
      if (!awready) begin awvalid = 1'b0; tmo("awready"); return; end
      @(posedge clk); #1;
      awvalid = 1'b0;
      chk("awready_drop", awready, 1'b0);
      wdata = {96'h0, d};
      wvalid = 1'b1;
      n = 0;
      while (!wready && n < 100) begin @(posedge clk); #1; n++; end
      if (!wready) begin wvalid = 1'b0; tmo("wready"); return; end
      @(posedge clk); #1;
      wvalid = 1'b0;
      er = m_write(a, d);
      chk("bvalid_next", bvalid, 1'b1);
      n = 0;
      while (!bvalid && n < 100) begin @(posedge clk); #1; n++; end
      if (!bvalid) begin tmo("bvalid"); return; end
      resp = bresp;
      r0 = bresp;
      chk("bid", bid, id);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("bvalid_hold", bvalid, 1'b1);
         chk("bresp_hold", bresp, r0);
         chk("bid_hold", bid, id);
         chk("awready_hold", awready, 1'b0);
      end
      bready = 1'b1;
      @(posedge clk); #1;
      bready = 1'b0;
      chk("bvalid_clr", bvalid, 1'b0);
      chk($sformatf("bresp@%02h", a), resp, er);
      chk("cc", cc, m_cc);
   endtask

   task automatic axi_read(input logic [5:0] a, input logic [15:0] id,
                           input int hold, input bit rx_en,
                           input logic [7:0] rx_b,
                           output logic [31:0] d, output logic [1:0] resp);
      int n;
      logic [31:0] ed;
      logic [1:0] er;
      logic [127:0] d0;
      d = 32'hffff_ffff;
      resp = 2'b11;
      araddr = a;
      arid = id;
      arvalid = 1'b1;
      n = 0;
      while (!arready && n < 100) begin @(posedge clk); #1; n++; end
      if (!arready) begin arvalid = 1'b0; tmo("arready"); return; end
      if (rx_en) begin rx_ready = 1'b1; rx_data = rx_b; end
      @(posedge clk); #1;
      arvalid = 1'b0;
      rx_ready = 1'b0;
      m_read(a, ed, er);
      if (rx_en) m_rx(rx_b);
      chk("rvalid_next", rvalid, 1'b1);
      n = 0;
      while (!rvalid && n < 100) begin @(posedge clk); #1; n++; end
      if (!rvalid) begin tmo("rvalid"); return; end
      d = rdata[31:0];
      resp = rresp;
      d0 = rdata;
      chk($sformatf("rdata@%02h", a), rdata, {96'h0, ed});
      chk($sformatf("rresp@%02h", a), rresp, er);
      chk("rid", rid, id);
      chk("rlast", rlast, 1'b1);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("rvalid_hold", rvalid, 1'b1);
         chk("rdata_hold", rdata, d0);
         chk("rid_hold", rid, id);
         chk("arready_hold", arready, 1'b0);
      end
      rready = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0;
      chk("rvalid_clr", rvalid, 1'b0);
   endtask

   task automatic rx_strobe(input logic [7:0] b);
      rx_ready = 1'b1;
      rx_data = b;
      @(posedge clk); #1;
      rx_ready = 1'b0;
      m_rx(b);
   endtask

   task automatic wait_tx_drain(input int budget);
      int n;
      n = 0;
      while ((tx_q.size() != 0 || tx_busy) && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      chk("tx_drained", tx_q.size(), 0);
   endtask

   typedef struct {
      bit          wr;
      logic [5:0]  addr;
      logic [31:0] data;
      logic [1:0]  resp;
      logic [31:0] rd;
      logic [3:0]  ccv;
   } vec_t;

   vec_t tbl[10];

   initial begin
      logic [1:0] r;
      logic [31:0] d;
      int p0, n;
      logic [5:0] bad[5];

      tbl[0] = '{0, 6'h08, 32'h0,        2'b00, 32'h0000_0005, 4'h0};
      tbl[1] = '{0, 6'h00, 32'h0,        2'b00, 32'h0,         4'h0};
      tbl[2] = '{1, 6'h04, 32'h5,        2'b00, 32'h0,         4'h5};
      tbl[3] = '{1, 6'h20, 32'hF,        2'b10, 32'h0,         4'h5};
      tbl[4] = '{0, 6'h04, 32'h0,        2'b10, 32'h0,         4'h5};
      tbl[5] = '{1, 6'h04, 32'hFFFF_FFFA, 2'b00, 32'h0,        4'hA};
      tbl[6] = '{0, 6'h3C, 32'h0,        2'b10, 32'h0,         4'hA};
      tbl[7] = '{1, 6'h08, 32'h3,        2'b00, 32'h0,         4'hA};
      tbl[8] = '{1, 6'h0C, 32'h0,        2'b10, 32'h0,         4'hA};
      tbl[9] = '{1, 6'h04, 32'h5,        2'b00, 32'h0,         4'h5};
      bad[0] = 6'h0C; bad[1] = 6'h10; bad[2] = 6'h20;
      bad[3] = 6'h3C; bad[4] = 6'h01;

      rst_n = 1'b0;
      awaddr = '0; awid = '0; awvalid = 1'b0;
      wdata = '0; wvalid = 1'b0; bready = 1'b0;
      araddr = '0; arid = '0; arvalid = 1'b0; rready = 1'b0;
      rx_ready = 1'b0; rx_data = '0;
      m_clear();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_awready", awready, 1'b0);
      chk("rst_arready", arready, 1'b0);
      chk("rst_bvalid", bvalid, 1'b0);
      chk("rst_rvalid", rvalid, 1'b0);
      chk("rst_tx_start", tx_start, 1'b0);
      chk("rst_cc", cc, 4'h0);
      chk("rst_rdata", rdata, 128'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("awready_up", awready, 1'b1);
      chk("arready_up", arready, 1'b1);

      for (int i = 0; i < 10; i++) begin
         if (tbl[i].wr) begin
            axi_write(tbl[i].addr, tbl[i].data, 16'(i), 0, r);
         end else begin
            axi_read(tbl[i].addr, 16'(i), 0, 1'b0, 8'h0, d, r);
            chk($sformatf("vec%0d_rd", i), d, tbl[i].rd);
         end
         chk($sformatf("vec%0d_resp", i), r, tbl[i].resp);
         chk($sformatf("vec%0d_cc", i), cc, tbl[i].ccv);
      end

      // three bytes paced by the UART
      p0 = pulses;
      axi_write(6'h00, 32'h41, 16'h0001, 0, r);
      axi_write(6'h00, 32'h42, 16'h0002, 0, r);
      axi_write(6'h00, 32'h43, 16'h0003, 0, r);
      wait_tx_drain(300);
      chk("t1_pulses", pulses - p0, 3);

      // TX overflow with the UART stuck busy
      busy_hold = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 17; i++) begin
         axi_write(6'h00, 32'(8'h60 + i), 16'(i), 0, r);
         chk($sformatf("t2_resp%0d", i), r, (i == 16) ? 2'b10 : 2'b00);
      end
      axi_read(6'h08, 16'h0222, 0, 1'b0, 8'h0, d, r);
      chk("t2_txovf", d[4], 1'b1);
      chk("t2_status", d, 32'h0000_1016);
      axi_write(6'h08, 32'h1, 16'h0223, 0, r);
      axi_read(6'h08, 16'h0224, 0, 1'b0, 8'h0, d, r);
      chk("t2_txovf_clr", d[4], 1'b0);
      busy_hold = 1'b0;
      p0 = pulses;
      wait_tx_drain(16 * 20 + 100);
      chk("t2_pulses", pulses - p0, 16);

      // RX bytes and empty read
      rx_strobe(8'h55);
      rx_strobe(8'hAA);
      axi_read(6'h00, 16'h0301, 0, 1'b0, 8'h0, d, r);
      chk("t3_first", d, 32'h155);
      axi_read(6'h00, 16'h0302, 0, 1'b0, 8'h0, d, r);
      chk("t3_second", d, 32'h1AA);
      axi_read(6'h00, 16'h0303, 0, 1'b0, 8'h0, d, r);
      chk("t3_empty_rd", d, 32'h0);
      axi_read(6'h08, 16'h0304, 0, 1'b0, 8'h0, d, r);
      chk("t3_rx_empty", d[2], 1'b1);

      // back-pressure on B and R
      axi_write(6'h04, 32'h3, 16'hBEEF, 5, r);
      axi_read(6'h08, 16'h1234, 5, 1'b0, 8'h0, d, r);

      // RX full with a coincident pop and push
      for (int i = 0; i < DEP; i++) rx_strobe(8'(8'h80 + i));
      axi_read(6'h08, 16'h0501, 0, 1'b0, 8'h0, d, r);
      chk("t5_full", d[3], 1'b1);
      axi_read(6'h00, 16'h0502, 0, 1'b1, 8'h77, d, r);
      chk("t5_pop", d, 32'h180);
      axi_read(6'h08, 16'h0503, 0, 1'b0, 8'h0, d, r);
      chk("t5_rxcnt", d[23:16], 8'd16);
      chk("t5_rxovf", d[5], 1'b0);
      rx_strobe(8'h99);
      axi_read(6'h08, 16'h0504, 0, 1'b0, 8'h0, d, r);
      chk("t5_ovf_set", d[5], 1'b1);
      axi_write(6'h08, 32'h2, 16'h0505, 0, r);
      for (int i = 0; i < DEP + 1; i++)
         axi_read(6'h00, 16'(i), 0, 1'b0, 8'h0, d, r);

      // randomized traffic, UART held busy so TX only fills
      busy_hold = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 250; i++) begin
         int op, hold;
         logic [15:0] id;
         op = $urandom_range(0, 7);
         hold = $urandom_range(0, 2);
         id = 16'($urandom);
         case (op)
            0, 1: axi_write(6'h00, $urandom, id, hold, r);
            2: axi_write(6'h04, $urandom, id, hold, r);
            3: axi_write(6'h08, 32'($urandom_range(0, 3)), id, hold, r);
            4: axi_read(6'h00, id, hold, 1'b0, 8'h0, d, r);
            5: axi_read(6'h08, id, hold, 1'b0, 8'h0, d, r);
            6: rx_strobe(8'($urandom));
            default: begin
               if ($urandom_range(0, 1) == 1)
                  axi_write(bad[$urandom_range(0, 4)], $urandom, id, hold, r);
               else
                  axi_read(bad[$urandom_range(0, 4)], id, hold, 1'b0, 8'h0, d, r);
            end
         endcase
      end
      axi_read(6'h08, 16'h0601, 0, 1'b0, 8'h0, d, r);
      busy_hold = 1'b0;
      wait_tx_drain(DEP * 20 + 100);

      // reset in the middle of a transmission
      for (int i = 0; i < 5; i++)
         axi_write(6'h00, 32'(8'hC0 + i), 16'(i), 0, r);
      n = 0;
      while (!tx_start && n < 200) begin @(negedge clk); n++; end
      if (!tx_start) tmo("t6_tx_start");
      #1;
      rst_n = 1'b0;
      #1;
      chk("t6_tx_start", tx_start, 1'b0);
      chk("t6_cc", cc, 4'h0);
      chk("t6_awready", awready, 1'b0);
      m_clear();
      @(posedge clk); #1;
      rst_n = 1'b1;
      p0 = pulses;
      repeat (40) @(posedge clk);
      #1;
      chk("t6_no_pulse", pulses - p0, 0);
      axi_read(6'h08, 16'h0701, 0, 1'b0, 8'h0, d, r);
      chk("t6_status", d, 32'h0000_0005);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
